clk_rst_seq_gen: RTL and testbench
==================================

CLK_RST_SEQ_GEN -- requirements
Module: clk_rst_seq_gen

Interface
Parameters:
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of clock-enable/reset channels, range 1..16.
REQ-002 The block SHALL have parameter DIV_W, default 8: divider field width in bits.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2: reset synchroniser depth, minimum 2.
REQ-004 The block SHALL have parameter RST_HOLD, default 16: cycles between synchronised reset release and channel 0 release, minimum 1.
REQ-005 The block SHALL have parameter RST_GAP, default 4: cycles between consecutive channel releases, minimum 1.
REQ-006 The block SHALL have parameter DIV_RST, default 0: divider value loaded on reset.
Ports:
REQ-007 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-008 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have port test_mode_i, input, 1 bit: scan/test bypass.
REQ-010 The block SHALL have port cfg_we_i, input, 1 bit: divider write strobe.
REQ-011 The block SHALL have port cfg_ch_i, input, $clog2(NUM_CH) bits (minimum 1): target channel.
REQ-012 The block SHALL have port cfg_div_i, input, DIV_W bits: new divider value.
REQ-013 The block SHALL have port clk_en_o, output, NUM_CH bits: per-channel one-cycle clock-enable pulse.
REQ-014 The block SHALL have port rstn_o, output, NUM_CH bits: per-channel active-low synchronous-release reset.
REQ-015 The block SHALL have port rst_done_o, output, 1 bit: high when all channels are released.

Function
REQ-016 rst_i SHALL feed a SYNC_STAGES flop chain: asynchronous assert, synchronous deassert.
REQ-017 The sequencer FSM SHALL have exactly four states: SYNC, HOLD, SEQ and DONE.
REQ-018 In SYNC, the FSM SHALL move to HOLD when the synchroniser output goes low.
REQ-019 HOLD SHALL count RST_HOLD cycles, then move to SEQ.
REQ-020 SEQ SHALL release one channel per step, in index order 0..NUM_CH-1, with RST_GAP cycles between steps.
REQ-021 The FSM SHALL move to DONE on the cycle the last channel is released.
REQ-022 Edge 1 is the first rising clk_i edge with rst_i low. rstn_o[0] SHALL rise at edge SYNC_STAGES+RST_HOLD.
REQ-023 rstn_o[k] SHALL rise RST_GAP*k edges after rstn_o[0].
REQ-024 rst_done_o SHALL rise on the same edge as rstn_o[NUM_CH-1].
REQ-025 Once released, rstn_o bits SHALL stay high until rst_i asserts.
REQ-026 Each channel SHALL have an active divider register and a shadow divider register, both DIV_W wide.
REQ-027 The divider counter SHALL count 0..div, then wrap to 0.
REQ-028 clk_en_o[k] SHALL be high for exactly one cycle, on the cycle when counter==div.
REQ-029 div=0 SHALL make clk_en_o[k] constantly high.
REQ-030 The pulse period SHALL be div+1 cycles.
REQ-031 While rstn_o[k] is low, counter k SHALL be held at 0 and clk_en_o[k] SHALL be 0.
REQ-032 The counter SHALL start at 0 on the cycle rstn_o[k] rises; the first pulse SHALL occur div+1 cycles later.
REQ-033 cfg_we_i SHALL write cfg_div_i into the shadow register of channel cfg_ch_i.
REQ-034 A write with cfg_ch_i >= NUM_CH SHALL be ignored.
REQ-035 Shadow SHALL be copied to active at the counter wrap (the cycle after a pulse) or at any cycle while the channel is in reset; no truncated or doubled periods.
REQ-036 On a simultaneous write and wrap for the same channel, the new value SHALL be captured into shadow and applied at the following wrap.
REQ-037 Back-to-back writes to one channel: last write wins.
REQ-038 While test_mode_i=1: rstn_o = {NUM_CH{~rst_i}} combinationally, clk_en_o = all ones, rst_done_o = ~rst_i; internal FSM and counters SHALL keep running unaffected.
REQ-039 Counters SHALL be DIV_W bits wide and never exceed div.
REQ-040 Lowering div below the current count SHALL take effect only after the wrap, so no overflow occurs.

Reset
REQ-041 Asserting rst_i SHALL asynchronously clear rstn_o=0, clk_en_o=0, rst_done_o=0, all counters=0, and active=shadow=DIV_RST.
REQ-042 Asserting rst_i SHALL asynchronously put the FSM in SYNC.
REQ-043 rst_i asserted mid-sequence or in DONE SHALL abort immediately and restart the full sequence from edge 1 after release.
REQ-044 A rst_i glitch shorter than one cycle SHALL still force a full resequence.

Verification
REQ-045 Defaults, rst_i released -> rstn_o[0] rises edge 18, rstn_o[1..3] at 22/26/30, rst_done_o at 30.
REQ-046 Channel 1, write div=3 during reset -> after release clk_en_o[1] pulses every 4 cycles, first pulse 4 cycles after rstn_o[1] rises.
REQ-047 Channel 0 running div=5, write div=1 two cycles after a pulse -> remaining period 6 completes, then period 2; no short pulse gap.
REQ-048 Write with cfg_ch_i=5, NUM_CH=4 -> no channel changes.
REQ-049 rst_i pulsed at edge 24 of sequence -> all outputs 0 asynchronously; re-release yields the timing of REQ-045.
REQ-050 test_mode_i=1, rst_i toggled -> rstn_o tracks ~rst_i with no clock edges, clk_en_o=4'b1111.

Source files
------------

// File: rtl/clk_rst_seq_gen.sv
// Reset sequencer: synchronises rst_i, releases per-channel resets in index order,
// and drives one programmable clock-enable divider per channel.

module clk_rst_seq_ch #(
    parameter int DIV_W   = 8,
    parameter int DIV_RST = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rstn_i,
    input  logic             we_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             en_o
);
    logic [DIV_W-1:0] cnt_q, act_q, shd_q;

    assign en_o = rstn_i && (cnt_q == act_q);

    // Active only reloads on wrap or while held in reset, so a period is never cut short.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            act_q <= DIV_W'(DIV_RST);
            shd_q <= DIV_W'(DIV_RST);
        end else begin
            if (we_i) shd_q <= div_i;
            if (!rstn_i || (cnt_q == act_q)) begin
                cnt_q <= '0;
                act_q <= shd_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

module clk_rst_seq_gen #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int RST_HOLD    = 16,
    parameter int RST_GAP     = 4,
    parameter int DIV_RST     = 0,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              test_mode_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    output logic [NUM_CH-1:0] clk_en_o,
    output logic [NUM_CH-1:0] rstn_o,
    output logic              rst_done_o
);
    localparam int CMAX  = (RST_HOLD > RST_GAP) ? RST_HOLD : RST_GAP;
    localparam int CNT_W = $clog2(CMAX + 1);

    typedef enum logic [1:0] {SYNC, HOLD, SEQ, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CH_W-1:0]        idx_q, idx_d;
    logic [NUM_CH-1:0]      rstn_q, rstn_d, en;
    logic                   done_q, done_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SYNC;
            cnt_q   <= '0;
            idx_q   <= '0;
            rstn_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rstn_q  <= rstn_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rstn_d  = rstn_q;
        done_d  = done_q;
        case (state_q)
            // Look one stage ahead so HOLD starts on the edge the synchroniser output drops.
            SYNC: if (!sync_q[SYNC_STAGES-2]) begin
                state_d = HOLD;
                cnt_d   = '0;
            end
            HOLD: if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
                rstn_d[0] = 1'b1;
                cnt_d     = '0;
                idx_d     = CH_W'(1);
                if (NUM_CH == 1) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = SEQ;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            SEQ: if (cnt_q == CNT_W'(RST_GAP - 1)) begin
                rstn_d[idx_q] = 1'b1;
                cnt_d         = '0;
                idx_d         = idx_q + 1'b1;
                if (idx_q == CH_W'(NUM_CH - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            DONE:    ;
            default: state_d = SYNC;
        endcase
    end

    // Out-of-range channel numbers match no instance, so those writes drop.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_rst_seq_ch #(
            .DIV_W   (DIV_W),
            .DIV_RST (DIV_RST)
        ) u_ch (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .rstn_i (rstn_q[k]),
            .we_i   (cfg_we_i && (cfg_ch_i == CH_W'(k))),
            .div_i  (cfg_div_i),
            .en_o   (en[k])
        );
    end

    assign rstn_o     = test_mode_i ? {NUM_CH{~rst_i}} : rstn_q;
    assign clk_en_o   = test_mode_i ? {NUM_CH{1'b1}}   : en;
    assign rst_done_o = test_mode_i ? ~rst_i           : done_q;
endmodule

// File: tb/tb_clk_rst_seq_gen.sv
// Directed bench for clk_rst_seq_gen: release timing, dividers, abort/glitch, test mode.

module tb_clk_rst_seq_gen;
    logic       clk_i = 1'b0, rst_i = 1'b1, test_mode_i = 1'b0;
    logic       cfg_we_i = 1'b0;
    logic [1:0] cfg_ch_i = '0;
    logic [7:0] cfg_div_i = '0;
    logic [3:0] clk_en_o, rstn_o;
    logic       rst_done_o;

    logic       cfg3_we = 1'b0;
    logic [1:0] cfg3_ch = '0;
    logic [7:0] cfg3_div = '0;
    logic [2:0] en3, rstn3;
    logic       done3;

    int          n_vec = 0, n_err = 0;
    int          rise[4];
    int          done_e, done3_e;
    logic [63:0] p[4];

    always #5 clk_i = ~clk_i;

    clk_rst_seq_gen dut (
        .clk_i(clk_i), .rst_i(rst_i), .test_mode_i(test_mode_i),
        .cfg_we_i(cfg_we_i), .cfg_ch_i(cfg_ch_i), .cfg_div_i(cfg_div_i),
        .clk_en_o(clk_en_o), .rstn_o(rstn_o), .rst_done_o(rst_done_o)
    );

    clk_rst_seq_gen #(.NUM_CH(3)) dut3 (
        .clk_i(clk_i), .rst_i(rst_i), .test_mode_i(test_mode_i),
        .cfg_we_i(cfg3_we), .cfg_ch_i(cfg3_ch), .cfg_div_i(cfg3_div),
        .clk_en_o(en3), .rstn_o(rstn3), .rst_done_o(done3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] span(input int lo, input int hi, input int step);
        logic [63:0] m = '0;
        for (int e = lo; e <= hi; e += step) m[e] = 1'b1;
        return m;
    endfunction

    // Edge e is the e-th rising edge with rst_i low; sampled 1ns after it.
    task automatic run(input int last_e, input bit cfg, input int abort_e);
        for (int k = 0; k < 4; k++) begin
            rise[k] = 0;
            p[k]    = '0;
        end
        done_e  = 0;
        done3_e = 0;
        if (cfg) begin
            cfg_we_i = 1'b1; cfg_ch_i = 2'd1; cfg_div_i = 8'd3;
            cfg3_we  = 1'b1; cfg3_ch  = 2'd3; cfg3_div  = 8'd7;
        end
        for (int e = 1; e <= last_e; e++) begin
            @(posedge clk_i); #1;
            if (cfg) begin
                if (e == 1)  begin cfg_ch_i = 2'd0; cfg_div_i = 8'd5; cfg3_we = 1'b0; end
                if (e == 2)  cfg_we_i = 1'b0;
                if (e == 30) begin cfg_we_i = 1'b1; cfg_ch_i = 2'd0; cfg_div_i = 8'd1; end
                if (e == 31) cfg_we_i = 1'b0;
            end
            for (int k = 0; k < 4; k++) begin
                if (rstn_o[k] && rise[k] == 0) rise[k] = e;
                p[k][e] = clk_en_o[k];
            end
            if (rst_done_o && done_e == 0) done_e = e;
            if (done3 && done3_e == 0) done3_e = e;
            if (e == abort_e) begin
                chk("pre_abort_rstn", 64'(rstn_o), 64'h3);
                rst_i = 1'b1; #1;
                chk("abort_rstn", 64'(rstn_o), 64'h0);
                chk("abort_en", 64'(clk_en_o), 64'h0);
                chk("abort_done", 64'(rst_done_o), 64'h0);
                rst_i = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        int l0[7] = '{23, 29, 35, 37, 39, 41, 43};
        logic [63:0] exp0;

        repeat (3) @(posedge clk_i); #1;
        chk("rst_rstn", 64'(rstn_o), 64'h0);
        chk("rst_en", 64'(clk_en_o), 64'h0);
        chk("rst_done", 64'(rst_done_o), 64'h0);

        // Normal release with divider programming.
        @(negedge clk_i); rst_i = 1'b0;
        run(44, 1'b1, 0);
        chk("rise0", 64'(rise[0]), 64'd18);
        chk("rise1", 64'(rise[1]), 64'd22);
        chk("rise2", 64'(rise[2]), 64'd26);
        chk("rise3", 64'(rise[3]), 64'd30);
        chk("done_edge", 64'(done_e), 64'd30);
        exp0 = '0;
        foreach (l0[i]) exp0[l0[i]] = 1'b1;
        chk("ch0_div5_to_1", p[0], exp0);
        chk("ch1_div3", p[1], span(25, 44, 4));
        chk("ch2_div0", p[2], span(26, 44, 1));
        chk("ch3_div0", p[3], span(30, 44, 1));
        chk("d3_done_edge", 64'(done3_e), 64'd26);
        chk("d3_oor_write", 64'(en3), 64'h7);

        // Sub-cycle reset glitch at edge 24, then a full resequence.
        @(negedge clk_i); rst_i = 1'b1;
        @(negedge clk_i); rst_i = 1'b0;
        run(44, 1'b0, 24);
        run(34, 1'b0, 0);
        chk("re_rise0", 64'(rise[0]), 64'd18);
        chk("re_rise1", 64'(rise[1]), 64'd22);
        chk("re_rise2", 64'(rise[2]), 64'd26);
        chk("re_rise3", 64'(rise[3]), 64'd30);
        chk("re_done_edge", 64'(done_e), 64'd30);
        chk("re_ch0_divrst", p[0], span(18, 34, 1));
        chk("re_ch1_divrst", p[1], span(22, 34, 1));

        // Test-mode bypass is combinational; internal sequencer keeps going.
        @(negedge clk_i); test_mode_i = 1'b1; rst_i = 1'b1; #1;
        chk("tm_rstn_asrt", 64'(rstn_o), 64'h0);
        chk("tm_en_asrt", 64'(clk_en_o), 64'hf);
        chk("tm_done_asrt", 64'(rst_done_o), 64'h0);
        #1 rst_i = 1'b0; #1;
        chk("tm_rstn_rel", 64'(rstn_o), 64'hf);
        chk("tm_done_rel", 64'(rst_done_o), 64'h1);
        chk("tm_en_rel", 64'(clk_en_o), 64'hf);
        repeat (10) @(posedge clk_i); #1;
        test_mode_i = 1'b0; #1;
        chk("tm_internal_hold", 64'(rstn_o), 64'h0);
        test_mode_i = 1'b1;
        repeat (24) @(posedge clk_i); #1;
        test_mode_i = 1'b0; #1;
        chk("tm_internal_rstn", 64'(rstn_o), 64'hf);
        chk("tm_internal_done", 64'(rst_done_o), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
